fpga_clock_top: RTL and testbench
=================================

# fpga_clock_top

Top level of a 24-hour digital clock on a 4-digit multiplexed 7-segment display, set with two push-buttons (Set, Up). It contains:
- the seconds prescaler and HH:MM:SS counters;
- button synchronisers and debouncers;
- the mode state machine;
- the display scan logic.

It sits directly on the board pins.

## Interface
- CLK_HZ, 32768: input clock frequency; one second = CLK_HZ cycles.
- DEBOUNCE_CYCLES, 512: cycles a synchronised button level must stay stable before it is accepted.
- SCAN_CYCLES, 32: cycles each digit is driven per scan slot.
- i_Clock  input  1  system clock; all logic on its rising edge.
- i_Reset_n  input  1  asynchronous, active-low reset.
- i_Button_Set  input  1  Set button, active high, asynchronous/bouncy.
- i_Button_Up  input  1  Up button, active high, asynchronous/bouncy.
- o_Segments  output  8  {dp, g, f, e, d, c, b, a}, active high.
- o_Digits  output  4  digit enables, active high; [0]=hour tens, [1]=hour units, [2]=minute tens, [3]=minute units.

## Operation
- Reset (asynchronous):
  - time = 00:00:00; prescaler = 0; mode = NORMAL; scan index = 0.
  - All debouncer states = released.
  - o_Segments = 0 and o_Digits = 0 while i_Reset_n is low.
- Buttons:
  - Each button passes a 2-flop synchroniser, then the debouncer.
  - The debounced level changes only after the synchronised input differs from it for DEBOUNCE_CYCLES consecutive cycles.
  - A press is a one-cycle pulse on the debounced 0→1 edge.
  - Release and glitches shorter than DEBOUNCE_CYCLES generate nothing.
- Mode FSM:
  - States: NORMAL → RESET_SEC → SET_MIN → SET_HOUR → NORMAL, advancing on each Set press.
  - RESET_SEC: seconds and prescaler are held at 0; hours and minutes are frozen.
  - SET_MIN / SET_HOUR: timekeeping keeps running.
  - SET_MIN: Up press → minutes = (minutes+1) mod 60, no carry into hours, seconds unchanged.
  - SET_HOUR: Up press → hours = (hours+1) mod 24.
  - Up presses in NORMAL and RESET_SEC are ignored.
  - Set and Up press pulses in the same cycle: Set wins; Up is discarded.
- Timekeeping:
  - The prescaler counts 0..CLK_HZ-1; on wrap, seconds increment.
  - Seconds 59→0 carries into minutes; minutes 59→0 carries into hours; 23:59:59 → 00:00:00.
  - If a tick carry and an Up increment of the same field coincide, the Up increment is applied and the carry into that field is dropped.
- Display:
  - The scan index cycles 0,1,2,3, advancing every SCAN_CYCLES cycles.
  - o_Digits = one-hot(scan index) AND mode mask.
  - Mode masks: NORMAL 1111; RESET_SEC 0000 (display blank); SET_MIN 1100; SET_HOUR 0011.
  - Segment encoding, bits g..a: 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111.
  - Hours and minutes are shown as two decimal digits with a leading zero.
  - dp = 1 only when the hour-units digit is scanned, mode is NORMAL and prescaler < CLK_HZ/2 (blinking colon). Otherwise dp = 0.
  - o_Segments shows the scanned digit's pattern even when its enable is masked.

## Timing
- Press latency: 2 synchroniser cycles + DEBOUNCE_CYCLES, then a 1-cycle pulse. The state or time update is visible on the following cycle.
- The seconds tick occurs every CLK_HZ cycles after reset release, or after leaving RESET_SEC.
- Outputs are registered: they change one cycle after the scan index or state change.
- A reset asserted mid-press or mid-setting returns all state to the reset values immediately; a held button must be released and pressed again to act.

## Test plan
- Reset, then 100 cycles → mode NORMAL.
  - Each enabled digit shows segments 0111111.
  - o_Digits walks 0001→0010→0100→1000 every 32 cycles.
  - dp = 1 on digit 1 during the first half second.
- 1 Set press → display blank (o_Digits=0000).
  - 2nd press → only 1100 enables appear.
  - 3rd press → only 0011 enables appear.
  - 4th press → NORMAL.
- Set×2, Up×2 → minute units shows 2 (1011011); hours still 00.
  - Then Set, Up → hour units shows 1 (0000110).
- Set hours to 23 and minutes to 59, return to NORMAL, wait 60×CLK_HZ cycles → display 00:00.
- Bounce 1/0 pulses of 5, 3, 2, 1 cycles, then hold for 1024 cycles → exactly one mode advance.
  - 10-cycle taps cause no advance.
- Set and Up press simultaneously in SET_MIN → mode SET_HOUR; minutes unchanged.

Source files
------------

// File: rtl/fpga_clock_top.sv
// 24-hour HH:MM clock on a multiplexed 4-digit 7-segment display, set with
// debounced Set/Up push-buttons through a four-state mode machine.
module fpga_clock_top #(
    parameter int CLK_HZ          = 32768,
    parameter int DEBOUNCE_CYCLES = 512,
    parameter int SCAN_CYCLES     = 32
) (
    input  logic       i_Clock,
    input  logic       i_Reset_n,
    input  logic       i_Button_Set,
    input  logic       i_Button_Up,
    output logic [7:0] o_Segments,
    output logic [3:0] o_Digits
);

    localparam int PRE_W  = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int DEB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int SCAN_W = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;

    localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(CLK_HZ - 1);
    localparam logic [PRE_W-1:0]  PRE_HALF  = PRE_W'(CLK_HZ / 2);
    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_CYCLES - 1);

    typedef enum logic [1:0] {
        MODE_NORMAL    = 2'd0,
        MODE_RESET_SEC = 2'd1,
        MODE_SET_MIN   = 2'd2,
        MODE_SET_HOUR  = 2'd3
    } mode_e;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b0111111;
            4'd1:    s = 7'b0000110;
            4'd2:    s = 7'b1011011;
            4'd3:    s = 7'b1001111;
            4'd4:    s = 7'b1100110;
            4'd5:    s = 7'b1101101;
            4'd6:    s = 7'b1111101;
            4'd7:    s = 7'b0000111;
            4'd8:    s = 7'b1111111;
            4'd9:    s = 7'b1101111;
            default: s = 7'b0000000;
        endcase
        return s;
    endfunction

    // Binary 0..59 to {tens, units}
    function automatic logic [7:0] to_bcd(input logic [5:0] v);
        logic [3:0] t;
        logic [5:0] u;
        if (v >= 6'd50)      t = 4'd5;
        else if (v >= 6'd40) t = 4'd4;
        else if (v >= 6'd30) t = 4'd3;
        else if (v >= 6'd20) t = 4'd2;
        else if (v >= 6'd10) t = 4'd1;
        else                 t = 4'd0;
        u = v - ({2'b00, t} * 6'd10);
        return {t, u[3:0]};
    endfunction

    // Button index 0 = Set, 1 = Up
    logic [1:0]       sync1_q, sync1_d, sync2_q, sync2_d;
    logic [1:0]       deb_q, deb_d, press_q, press_d;
    logic [DEB_W-1:0] deb_cnt_q [2];
    logic [DEB_W-1:0] deb_cnt_d [2];

    mode_e             mode_q, mode_d;
    logic [PRE_W-1:0]  pre_q, pre_d;
    logic [5:0]        sec_q, sec_d, min_q, min_d;
    logic [4:0]        hour_q, hour_d;
    logic [SCAN_W-1:0] scan_cnt_q, scan_cnt_d;
    logic [1:0]        scan_idx_q, scan_idx_d;
    logic [7:0]        seg_q, seg_d;
    logic [3:0]        dig_q, dig_d;

    logic       set_press_s, up_press_s, up_min_s, up_hour_s;
    logic       tick_s, sec_wrap_s, min_wrap_s, dp_s;
    logic [7:0] hour_bcd_s, min_bcd_s;
    logic [3:0] digit_s, mask_s;

    // Synchronise and debounce both buttons; press pulse on accepted rising level
    always_comb begin
        sync1_d = {i_Button_Up, i_Button_Set};
        sync2_d = sync1_q;
        deb_d   = deb_q;
        press_d = 2'b00;
        for (int b = 0; b < 2; b++) begin
            deb_cnt_d[b] = {DEB_W{1'b0}};
            if (sync2_q[b] != deb_q[b]) begin
                if (deb_cnt_q[b] == DEB_LAST) begin
                    deb_d[b]   = sync2_q[b];
                    press_d[b] = sync2_q[b];
                end else begin
                    deb_cnt_d[b] = deb_cnt_q[b] + DEB_W'(1);
                end
            end else begin
                deb_cnt_d[b] = {DEB_W{1'b0}};
            end
        end
    end

    assign set_press_s = press_q[0];
    assign up_press_s  = press_q[1] & ~press_q[0];

    // Mode next-state: each Set press advances one step round the ring
    always_comb begin
        mode_d = mode_q;
        if (set_press_s) begin
            case (mode_q)
                MODE_NORMAL:    mode_d = MODE_RESET_SEC;
                MODE_RESET_SEC: mode_d = MODE_SET_MIN;
                MODE_SET_MIN:   mode_d = MODE_SET_HOUR;
                MODE_SET_HOUR:  mode_d = MODE_NORMAL;
                default:        mode_d = MODE_NORMAL;
            endcase
        end else begin
            mode_d = mode_q;
        end
    end

    // Timekeeping: an Up increment of a field overrides a tick carry into it
    always_comb begin
        tick_s     = (pre_q == PRE_LAST);
        sec_wrap_s = tick_s && (sec_q == 6'd59);
        min_wrap_s = sec_wrap_s && (min_q == 6'd59);
        up_min_s   = up_press_s && (mode_q == MODE_SET_MIN);
        up_hour_s  = up_press_s && (mode_q == MODE_SET_HOUR);
        pre_d      = pre_q;
        sec_d      = sec_q;
        min_d      = min_q;
        hour_d     = hour_q;
        if (mode_q == MODE_RESET_SEC) begin
            pre_d = {PRE_W{1'b0}};
            sec_d = 6'd0;
        end else begin
            pre_d = tick_s ? {PRE_W{1'b0}} : pre_q + PRE_W'(1);
            if (tick_s) begin
                sec_d = sec_wrap_s ? 6'd0 : sec_q + 6'd1;
            end else begin
                sec_d = sec_q;
            end
            if (up_min_s) begin
                min_d = (min_q == 6'd59) ? 6'd0 : min_q + 6'd1;
            end else if (sec_wrap_s) begin
                min_d = min_wrap_s ? 6'd0 : min_q + 6'd1;
            end else begin
                min_d = min_q;
            end
            if (up_hour_s) begin
                hour_d = (hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1;
            end else if (min_wrap_s && !up_min_s) begin
                hour_d = (hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1;
            end else begin
                hour_d = hour_q;
            end
        end
    end

    // Scan slot counter and registered segment/enable outputs
    always_comb begin
        if (scan_cnt_q == SCAN_LAST) begin
            scan_cnt_d = {SCAN_W{1'b0}};
            scan_idx_d = scan_idx_q + 2'd1;
        end else begin
            scan_cnt_d = scan_cnt_q + SCAN_W'(1);
            scan_idx_d = scan_idx_q;
        end
        hour_bcd_s = to_bcd({1'b0, hour_q});
        min_bcd_s  = to_bcd(min_q);
        case (scan_idx_q)
            2'd0:    digit_s = hour_bcd_s[7:4];
            2'd1:    digit_s = hour_bcd_s[3:0];
            2'd2:    digit_s = min_bcd_s[7:4];
            2'd3:    digit_s = min_bcd_s[3:0];
            default: digit_s = 4'd0;
        endcase
        case (mode_q)
            MODE_NORMAL:    mask_s = 4'b1111;
            MODE_RESET_SEC: mask_s = 4'b0000;
            MODE_SET_MIN:   mask_s = 4'b1100;
            MODE_SET_HOUR:  mask_s = 4'b0011;
            default:        mask_s = 4'b0000;
        endcase
        dp_s  = (scan_idx_q == 2'd1) && (mode_q == MODE_NORMAL) && (pre_q < PRE_HALF);
        dig_d = (4'b0001 << scan_idx_q) & mask_s;
        seg_d = {dp_s, seg7(digit_s)};
    end

    // State registers
    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            sync1_q      <= 2'b00;
            sync2_q      <= 2'b00;
            deb_q        <= 2'b00;
            press_q      <= 2'b00;
            deb_cnt_q[0] <= {DEB_W{1'b0}};
            deb_cnt_q[1] <= {DEB_W{1'b0}};
            mode_q       <= MODE_NORMAL;
            pre_q        <= {PRE_W{1'b0}};
            sec_q        <= 6'd0;
            min_q        <= 6'd0;
            hour_q       <= 5'd0;
            scan_cnt_q   <= {SCAN_W{1'b0}};
            scan_idx_q   <= 2'd0;
            seg_q        <= 8'd0;
            dig_q        <= 4'd0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            deb_q      <= deb_d;
            press_q    <= press_d;
            deb_cnt_q  <= deb_cnt_d;
            mode_q     <= mode_d;
            pre_q      <= pre_d;
            sec_q      <= sec_d;
            min_q      <= min_d;
            hour_q     <= hour_d;
            scan_cnt_q <= scan_cnt_d;
            scan_idx_q <= scan_idx_d;
            seg_q      <= seg_d;
            dig_q      <= dig_d;
        end
    end

    assign o_Segments = seg_q;
    assign o_Digits   = dig_q;

endmodule

// File: tb/tb_fpga_clock_top.sv
// Scoreboard bench for fpga_clock_top: stimulus queues expected display frames,
// a monitor samples each frame of the scan and compares.
module tb_fpga_clock_top;

    localparam int CLK_HZ = 256;
    localparam int DEB    = 16;
    localparam int SCAN   = 4;
    localparam int FRAME  = 5 * SCAN;
    localparam int DP_NONE = 0;
    localparam int DP_SEEN = 1;
    localparam int DP_ANY  = 2;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       b_set = 1'b0;
    logic       b_up  = 1'b0;
    logic [7:0] seg;
    logic [3:0] dig;

    fpga_clock_top #(
        .CLK_HZ(CLK_HZ),
        .DEBOUNCE_CYCLES(DEB),
        .SCAN_CYCLES(SCAN)
    ) dut (
        .i_Clock(clk),
        .i_Reset_n(rst_n),
        .i_Button_Set(b_set),
        .i_Button_Up(b_up),
        .o_Segments(seg),
        .o_Digits(dig)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_reset;
        logic [3:0]  mask;
        logic [15:0] digs;
        int          dp_mode;
        bit          walk;
        string       name;
    } exp_t;

    exp_t q[$];
    exp_t cur;
    bit   busy = 1'b0;
    int   n_assert = 0;
    int   n_fail = 0;

    function automatic logic [6:0] exp_seg(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b0111111;
            4'd1:    return 7'b0000110;
            4'd2:    return 7'b1011011;
            4'd3:    return 7'b1001111;
            4'd4:    return 7'b1100110;
            4'd5:    return 7'b1101101;
            4'd6:    return 7'b1111101;
            4'd7:    return 7'b0000111;
            4'd8:    return 7'b1111111;
            4'd9:    return 7'b1101111;
            default: return 7'b0000000;
        endcase
    endfunction

    // Digit nibbles in enable order: [3:0] hour tens .. [15:12] minute units
    function automatic logic [15:0] hhmm(input int h, input int m);
        logic [3:0] a, b, c, d;
        a = 4'(h / 10);
        b = 4'(h % 10);
        c = 4'(m / 10);
        d = 4'(m % 10);
        return {d, c, b, a};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_assert++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: pop one expectation and observe the display for one frame
    logic [3:0] seen;
    logic [6:0] got [4];
    bit         dp1, dpx, illegal, walk_bad, full_run;
    int         run;
    logic [3:0] prev;

    initial begin
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                cur  = q.pop_front();
                busy = 1'b1;
                if (cur.is_reset) begin
                    check({cur.name, "_seg"}, {24'd0, seg}, 32'd0);
                    check({cur.name, "_dig"}, {28'd0, dig}, 32'd0);
                end else begin
                    seen = 4'd0; dp1 = 1'b0; dpx = 1'b0; illegal = 1'b0;
                    walk_bad = 1'b0; full_run = 1'b0; run = 0; prev = dig;
                    for (int k = 0; k < 4; k++) got[k] = 7'd0;
                    for (int c = 0; c < FRAME; c++) begin
                        if (c > 0) @(negedge clk);
                        if (!$onehot0(dig)) illegal = 1'b1;
                        for (int k = 0; k < 4; k++) begin
                            if (dig[k]) begin
                                if (!seen[k]) got[k] = seg[6:0];
                                seen[k] = 1'b1;
                                if (seg[7]) begin
                                    if (k == 1) dp1 = 1'b1;
                                    else dpx = 1'b1;
                                end
                            end
                        end
                        if (c > 0 && dig != prev) begin
                            if (prev != 4'd0 && dig != 4'd0 && dig != {prev[2:0], prev[3]})
                                walk_bad = 1'b1;
                            if (full_run && run != SCAN) walk_bad = 1'b1;
                            full_run = 1'b1;
                            run = 1;
                        end else begin
                            run++;
                        end
                        prev = dig;
                    end
                    check({cur.name, "_mask"}, {27'd0, illegal, seen}, {28'd0, cur.mask});
                    for (int k = 0; k < 4; k++)
                        if (cur.mask[k])
                            check($sformatf("%s_digit%0d", cur.name, k), {25'd0, got[k]},
                                  {25'd0, exp_seg(cur.digs[k*4 +: 4])});
                    if (cur.dp_mode != DP_ANY)
                        check({cur.name, "_dp"}, {31'd0, dp1}, 32'(cur.dp_mode));
                    check({cur.name, "_dp_other"}, {31'd0, dpx}, 32'd0);
                    if (cur.walk) check({cur.name, "_walk"}, {31'd0, walk_bad}, 32'd0);
                end
                busy = 1'b0;
            end
        end
    end

    task automatic wait_done(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 4 * FRAME; i++) begin
            @(negedge clk);
            #1;
            if (q.size() == 0 && !busy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_assert++;
            n_fail++;
            $display("FAIL %s_timeout: actual=pending required=done", name);
        end
    endtask

    task automatic expect_frame(input string name, input logic [3:0] mask,
                                input logic [15:0] digs, input int dp_mode, input bit walk);
        exp_t e;
        e.is_reset = 1'b0; e.mask = mask; e.digs = digs;
        e.dp_mode = dp_mode; e.walk = walk; e.name = name;
        q.push_back(e);
        wait_done(name);
    endtask

    task automatic expect_reset(input string name);
        exp_t e;
        e.is_reset = 1'b1; e.mask = 4'd0; e.digs = 16'd0;
        e.dp_mode = DP_ANY; e.walk = 1'b0; e.name = name;
        q.push_back(e);
        wait_done(name);
    endtask

    task automatic press(input bit s, input bit u);
        @(negedge clk);
        b_set = s;
        b_up  = u;
        repeat (DEB + 10) @(negedge clk);
        b_set = 1'b0;
        b_up  = 1'b0;
        repeat (DEB + 10) @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int widths [4];
        widths = '{5, 3, 2, 1};

        repeat (5) @(negedge clk);
        expect_reset("reset_low");
        @(negedge clk);
        rst_n = 1'b1;
        expect_frame("after_reset", 4'hF, hhmm(0, 0), DP_SEEN, 1'b1);
        repeat (140) @(negedge clk);
        expect_frame("second_half", 4'hF, hhmm(0, 0), DP_NONE, 1'b1);

        press(1'b1, 1'b0); expect_frame("set1_blank", 4'b0000, hhmm(0, 0), DP_NONE, 1'b0);
        press(1'b1, 1'b0); expect_frame("set2_min", 4'b1100, hhmm(0, 0), DP_NONE, 1'b0);
        press(1'b1, 1'b0); expect_frame("set3_hour", 4'b0011, hhmm(0, 0), DP_NONE, 1'b0);
        press(1'b1, 1'b0); expect_frame("set4_normal", 4'hF, hhmm(0, 0), DP_ANY, 1'b1);
        press(1'b0, 1'b1); expect_frame("up_in_normal", 4'hF, hhmm(0, 0), DP_ANY, 1'b1);

        press(1'b1, 1'b0); press(1'b1, 1'b0);
        press(1'b0, 1'b1); press(1'b0, 1'b1);
        expect_frame("min_up2", 4'b1100, hhmm(0, 2), DP_NONE, 1'b0);
        press(1'b1, 1'b0); press(1'b0, 1'b1);
        expect_frame("hour_up1", 4'b0011, hhmm(1, 2), DP_NONE, 1'b0);

        repeat (22) press(1'b0, 1'b1);
        expect_frame("hour_23", 4'b0011, hhmm(23, 2), DP_NONE, 1'b0);
        press(1'b1, 1'b0); press(1'b1, 1'b0); press(1'b1, 1'b0);
        repeat (57) press(1'b0, 1'b1);
        expect_frame("min_59", 4'b1100, hhmm(23, 59), DP_NONE, 1'b0);
        press(1'b1, 1'b0); press(1'b1, 1'b0);
        expect_frame("at_2359", 4'hF, hhmm(23, 59), DP_ANY, 1'b1);
        repeat (60 * CLK_HZ) @(negedge clk);
        expect_frame("rollover", 4'hF, hhmm(0, 0), DP_ANY, 1'b1);

        // Bouncy press followed by a long hold: one advance only
        foreach (widths[i]) begin
            b_set = 1'b1; repeat (widths[i]) @(negedge clk);
            b_set = 1'b0; repeat (widths[i]) @(negedge clk);
        end
        b_set = 1'b1; repeat (1024) @(negedge clk);
        b_set = 1'b0; repeat (DEB + 10) @(negedge clk);
        expect_frame("bounce_one_advance", 4'b0000, hhmm(0, 0), DP_NONE, 1'b0);
        repeat (6) begin
            b_set = 1'b1; repeat (10) @(negedge clk);
            b_set = 1'b0; repeat (10) @(negedge clk);
        end
        repeat (DEB + 10) @(negedge clk);
        expect_frame("short_taps", 4'b0000, hhmm(0, 0), DP_NONE, 1'b0);

        press(1'b1, 1'b0); expect_frame("to_set_min", 4'b1100, hhmm(0, 0), DP_NONE, 1'b0);
        press(1'b1, 1'b1); expect_frame("set_up_same", 4'b0011, hhmm(0, 0), DP_NONE, 1'b0);
        press(1'b1, 1'b0); expect_frame("set_wins", 4'hF, hhmm(0, 0), DP_ANY, 1'b1);

        press(1'b1, 1'b0); press(1'b1, 1'b0); press(1'b0, 1'b1);
        expect_frame("pre_reset_min", 4'b1100, hhmm(0, 1), DP_NONE, 1'b0);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        expect_reset("mid_setting_reset");
        @(negedge clk);
        rst_n = 1'b1;
        expect_frame("after_mid_reset", 4'hF, hhmm(0, 0), DP_SEEN, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
